// File: rtl/memshare_vn_iblut_loader.sv
// Write-side loader for a VN information-bottleneck LUT: streams one page of
// entries into ascending LUT addresses, then pulses done and holds lut_valid.
module memshare_vn_iblut_loader #(
  parameter int WR_ADDR_BITWIDTH = 6,
  parameter int WR_BITWIDTH      = 4,
  parameter int VN_LOAD_CYCLE    = 64
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [WR_BITWIDTH-1:0]      entry_i,
  input  logic                        entry_valid_i,
  output logic                        entry_ready_o,
  output logic [WR_ADDR_BITWIDTH-1:0] waddr_o,
  output logic [WR_BITWIDTH-1:0]      wdata_o,
  output logic                        wen_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        lut_valid_o
);

  localparam int CW = WR_ADDR_BITWIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(VN_LOAD_CYCLE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            lut_valid_q;
  logic            start_acc;
  logic            hs;

  // Abort wins over a same-cycle handshake, so the entry is simply not taken.
  assign hs        = (state == LOAD) && entry_valid_i && !abort_i;
  assign start_acc = (state == IDLE) && start_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    if (abort_i) state_nxt = IDLE;
               else if (hs && cnt == LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = abort_i ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write port is registered: a handshake in cycle k is on the bus in k+1.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      wen_o       <= 1'b1;
      lut_valid_q <= 1'b0;
    end else begin
      wen_o <= !hs;
      if (hs) begin
        waddr_o <= cnt[WR_ADDR_BITWIDTH-1:0];
        wdata_o <= entry_i;
      end
      if (start_acc)  cnt <= '0;
      else if (hs)    cnt <= cnt + CW'(1);
      if (start_acc)                        lut_valid_q <= 1'b0;
      else if (state == FLUSH && !abort_i)  lut_valid_q <= 1'b1;
    end
  end

  assign entry_ready_o = (state == LOAD);
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign lut_valid_o   = lut_valid_q;

endmodule

// File: doc/memshare_vn_iblut_loader.md
# memShare_vn_ibLUT_loader

Write-side controller for the VN information-bottleneck LUT cell. It accepts a start request and a valid/ready stream of LUT entries, and generates the LUT write port: address, data, and active-LOW write enable. One page of VN_LOAD_CYCLE entries is written at ascending addresses, then a completion pulse is raised and a LUT-valid flag is held for the VN read side. It sits between the LUT-content source (config memory / DMA) and each VN IB LUT cell.

## Interface
- WR_ADDR_BITWIDTH, 6, LUT write-address width; VN_LOAD_CYCLE ≤ 2^WR_ADDR_BITWIDTH
- WR_BITWIDTH, 4, LUT entry (write data) width
- VN_LOAD_CYCLE, 64, entries per load; legal range 1..2^WR_ADDR_BITWIDTH
- sys_clk  input  1  single clock; all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle load request; honoured only in IDLE
- abort_i  input  1  cancel an in-progress load
- entry_i  input  WR_BITWIDTH  upstream LUT entry
- entry_valid_i  input  1  entry_i valid
- entry_ready_o  output  1  loader accepts entry_i
- waddr_o  output  WR_ADDR_BITWIDTH  LUT write address
- wdata_o  output  WR_BITWIDTH  LUT write data
- wen_o  output  1  LUT write enable, active LOW
- busy_o  output  1  load in progress (state ≠ IDLE)
- done_o  output  1  one-cycle pulse: full page committed
- lut_valid_o  output  1  LUT holds a complete page; safe to read

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE: entry_ready_o=0. start_i=1 moves to LOAD, clears the entry counter cnt to 0, and clears lut_valid_o.
- LOAD: entry_ready_o=1.
  - A handshake (entry_valid_i & entry_ready_o) registers a write of entry_i to address cnt, then increments cnt.
  - A handshake with cnt==VN_LOAD_CYCLE-1 moves to FLUSH.
  - Cycles without valid produce no write (wen_o=1). Stalls are unbounded.
- FLUSH: entry_ready_o=0. The last write is on the bus. Next state is DONE.
- DONE: done_o=1 and lut_valid_o set to 1. Next state is IDLE.
- abort_i in LOAD or FLUSH: go to IDLE, wen_o=1 next cycle, lut_valid_o stays 0, no done_o. Any write already on the bus in the abort cycle still completes. abort_i has priority over a same-cycle handshake: that entry is dropped. abort_i in IDLE or DONE is ignored.
- start_i outside IDLE is ignored; it is not queued.
- Counter width is WR_ADDR_BITWIDTH+1 bits, so cnt cannot wrap before the terminal compare. waddr_o takes the low WR_ADDR_BITWIDTH bits.
- Entries with entry_valid_i outside LOAD are not consumed.

## Timing
- Reset (async assert, sync deassert expected): state=IDLE, cnt=0, wen_o=1, waddr_o=0, wdata_o=0, entry_ready_o=0, busy_o=0, done_o=0, lut_valid_o=0. Reset mid-load returns to IDLE immediately; the LUT contents are undefined and must be reloaded.
- Write outputs are registered:
  - A handshake in cycle k drives wen_o=0 with waddr_o/wdata_o during cycle k+1.
  - The LUT captures the write at the end of cycle k+1.
  - Outside write cycles, waddr_o/wdata_o hold their last value and wen_o=1.
- entry_ready_o is a pure state decode with no combinational path from entry_valid_i.
- start_i in cycle s gives LOAD (ready=1) in cycle s+1.
- The last handshake in cycle k gives FLUSH plus the last write in k+1, then done_o and lut_valid_o rising in k+2, then IDLE in k+3.
- Minimum load duration, start to done_o, is VN_LOAD_CYCLE+2 cycles.
- lut_valid_o falls in the cycle after start_i is accepted.

## Test plan
- Reset then start, with entry_valid_i held 1 and entries 0..63 equal to addr[3:0]: 64 consecutive writes, wen_o=0 at addresses 0..63; done_o pulses exactly 66 cycles after start_i; lut_valid_o=1 afterwards.
- Same load, with entry_valid_i toggling every other cycle: writes only on cycles following a handshake; addresses contiguous, no skips or duplicates; done_o only after the 64th entry.
- abort_i asserted after 10 handshakes, concurrent with the 11th valid: exactly 10 writes (addresses 0..9); entry 11 dropped; back to IDLE; no done_o; lut_valid_o=0. A following start reloads from address 0.
- start_i pulsed during LOAD and in the DONE cycle: ignored, with no counter reset and no second load. After IDLE, a new start_i clears lut_valid_o next cycle.
- rst asserted at handshake 30: all outputs return to reset values asynchronously, and wen_o=1 within the same cycle. entry_valid_i held afterward without start_i gives no writes.
- VN_LOAD_CYCLE=1 build: a single handshake produces one write at address 0, and done_o pulses 2 cycles later.
